// File: rtl/matrix_row_driver.sv
// Row driver for a 5x7 LED matrix: filters the one-hot column strobe and drives the glyph column slice.
// Latency col_sel -> row is SYNC_STAGES+2 cycles; char_ready drops while a code waits for the next frame.
// Backpressure: char_valid without char_ready is ignored. MATRIX_PWM_EN adds the duty port and row gating.
module matrix_row_driver #(
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] col_sel,
    input  logic [3:0] char_code,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [6:0] row,
    output logic       blank,
    output logic       frame_start
`ifdef MATRIX_PWM_EN
    ,
    input  logic [2:0] duty
`endif
);

    // Columns listed C0..C4, bit 0 of each column is the top row.
    function automatic logic [6:0] glyph_col(input logic [3:0] code, input logic [2:0] col);
        logic [34:0] g;
        case (code)
            4'h0:    g = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
            4'h1:    g = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
            4'h2:    g = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
            4'h3:    g = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
            4'h4:    g = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
            4'h5:    g = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
            4'h6:    g = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
            4'h7:    g = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
            4'h8:    g = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            4'h9:    g = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
            4'hA:    g = {7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F};
            4'hB:    g = {7'h46, 7'h49, 7'h49, 7'h49, 7'h31};
            4'hC:    g = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
            4'hD:    g = {7'h7C, 7'h08, 7'h04, 7'h04, 7'h08};
            4'hE:    g = {7'h08, 7'h08, 7'h08, 7'h08, 7'h08};
            default: g = '0;
        endcase
        return g[(34 - 7 * int'(col)) -: 7];
    endfunction

    logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
    logic [4:0] s_prev_q, s_prev_d;
    logic [4:0] col_q, col_d;
    logic [6:0] row_lit_q, row_lit_d;
    logic       blank_q, blank_d;
    logic       frame_start_q, frame_start_d;
    logic       pending_q, pending_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] active_q, active_d;
    logic [4:0] s_n;
    logic       col_stable;
    logic       one_hot;
    logic [2:0] col_idx;
    logic       swap;
    logic [6:0] row_lit;

    assign char_ready = !pending_q && !rst;

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], col_sel};
        s_n           = sync_q[SYNC_STAGES-1];
        s_prev_d      = s_n;
        col_stable    = (s_n == s_prev_q);
        col_d         = col_q;
        row_lit_d     = row_lit_q;
        blank_d       = blank_q;
        frame_start_d = 1'b0;
        pending_d     = pending_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        swap          = 1'b0;
        one_hot       = 1'b1;
        col_idx       = 3'd0;
        case (s_n)
            5'b00001: col_idx = 3'd0;
            5'b00010: col_idx = 3'd1;
            5'b00100: col_idx = 3'd2;
            5'b01000: col_idx = 3'd3;
            5'b10000: col_idx = 3'd4;
            default:  one_hot = 1'b0;
        endcase
        // Unstable samples (ripple glitches) leave row/blank untouched.
        if (col_stable) begin
            col_d         = s_n;
            frame_start_d = (s_n == 5'b00001) && (col_q != 5'b00001);
            swap          = frame_start_d && pending_q;
            if (swap) begin
                active_d = shadow_q;
            end
            row_lit_d = one_hot ? glyph_col(active_d, col_idx) : 7'd0;
            blank_d   = !one_hot;
        end
        if (char_valid && char_ready) begin
            shadow_d  = char_code;
            pending_d = 1'b1;
        end else if (swap) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= '0;
            s_prev_q      <= '0;
            col_q         <= '0;
            row_lit_q     <= '0;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            pending_q     <= 1'b0;
            shadow_q      <= 4'hF;
            active_q      <= 4'hF;
        end else begin
            sync_q        <= sync_d;
            s_prev_q      <= s_prev_d;
            col_q         <= col_d;
            row_lit_q     <= row_lit_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

`ifdef MATRIX_PWM_EN
    logic [2:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 3'd1;
        row_lit   = (pwm_cnt_q <= duty) ? row_lit_q : 7'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`else
    assign row_lit = row_lit_q;
`endif

    assign row         = ROW_ACTIVE_LOW ? ~row_lit : row_lit;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_row_driver.sv
// Testbench for matrix_row_driver: directed scenarios then random column/handshake traffic,
// every cycle compared against a history-based reference model of the display rules.
module tb_matrix_row_driver;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] col_sel = '0;
    logic [3:0] char_code = '0;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic [6:0] row;
    logic       blank;
    logic       frame_start;
`ifdef MATRIX_PWM_EN
    logic [2:0] duty = 3'd7;
`endif

    always #5 clk = ~clk;

    matrix_row_driver #(.ROW_ACTIVE_LOW(1'b0), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .col_sel(col_sel), .char_code(char_code),
        .char_valid(char_valid), .char_ready(char_ready), .row(row),
        .blank(blank), .frame_start(frame_start)
`ifdef MATRIX_PWM_EN
        , .duty(duty)
`endif
    );

    int checks = 0;
    int errors = 0;
    int fs_count = 0;

    // Reference state: input history (hist[k] = col_sel sampled k+1 edges ago) plus handshake/display state.
    logic [4:0] hist [S+1];
    logic [6:0] font [16][5];
    logic       m_pending = 1'b0;
    logic [3:0] m_shadow = 4'hF;
    logic [3:0] m_active = 4'hF;
    logic [6:0] m_row = '0;
    logic       m_blank = 1'b1;
    logic       m_fs = 1'b0;
    logic [4:0] m_last = '0;
    int         m_pwm = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [4:0] c, input logic v, input logic [3:0] code, input logic r);
        logic [4:0] sn;
        logic [4:0] sp;
        logic       swap;
        if (r) begin
            for (int i = 0; i <= S; i++) hist[i] = '0;
            m_pending = 1'b0; m_shadow = 4'hF; m_active = 4'hF;
            m_row = '0; m_blank = 1'b1; m_fs = 1'b0; m_last = '0; m_pwm = 0;
        end else begin
            sn = hist[S-1];
            sp = hist[S];
            m_fs = 1'b0;
            swap = 1'b0;
            if (sn == sp) begin
                m_fs = (sn == 5'd1) && (m_last != 5'd1);
                swap = m_fs && m_pending;
                if (swap) m_active = m_shadow;
                m_last = sn;
                if ($countones(sn) == 1) begin
                    m_row = font[m_active][$clog2(sn)];
                    m_blank = 1'b0;
                end else begin
                    m_row = '0;
                    m_blank = 1'b1;
                end
            end
            if (v && !m_pending) begin
                m_shadow = code;
                m_pending = 1'b1;
            end else if (swap) begin
                m_pending = 1'b0;
            end
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = c;
            m_pwm = (m_pwm + 1) % 8;
        end
    endtask

    function automatic logic [6:0] exp_row();
`ifdef MATRIX_PWM_EN
        return (m_pwm <= int'(duty)) ? m_row : 7'd0;
`else
        return m_row;
`endif
    endfunction

    task automatic step(input logic [4:0] c, input logic v, input logic [3:0] code, input logic r);
        col_sel = c; char_valid = v; char_code = code; rst = r;
        #1;
        chk("char_ready", {31'd0, char_ready}, {31'd0, !m_pending && !r});
        @(posedge clk);
        model_edge(c, v, code, r);
        @(negedge clk);
        chk("row", {25'd0, row}, {25'd0, exp_row()});
        chk("blank", {31'd0, blank}, {31'd0, m_blank});
        chk("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
        if (frame_start === 1'b1) fs_count++;
    endtask

    task automatic hold(input logic [4:0] c, input int n);
        for (int i = 0; i < n; i++) step(c, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        logic [4:0] c;
        int         n;
        font[0]  = '{7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
        font[1]  = '{7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
        font[2]  = '{7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
        font[3]  = '{7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
        font[4]  = '{7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
        font[5]  = '{7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
        font[6]  = '{7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
        font[7]  = '{7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
        font[8]  = '{7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
        font[9]  = '{7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
        font[10] = '{7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F};
        font[11] = '{7'h46, 7'h49, 7'h49, 7'h49, 7'h31};
        font[12] = '{7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
        font[13] = '{7'h7C, 7'h08, 7'h04, 7'h04, 7'h08};
        font[14] = '{7'h08, 7'h08, 7'h08, 7'h08, 7'h08};
        font[15] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        for (int i = 0; i <= S; i++) hist[i] = '0;

        // Reset for three cycles
        repeat (3) step(5'd0, 1'b0, 4'h0, 1'b1);
        chk("rst_row", {25'd0, row}, 32'h00);
        chk("rst_blank", {31'd0, blank}, 32'd1);
        rst = 1'b0; #1;
        chk("ready_after_rst", {31'd0, char_ready}, 32'd1);

        // Dash glyph through C0..C2, exactly one frame pulse
        step(5'd0, 1'b1, 4'hE, 1'b0);
        fs_count = 0;
        hold(5'b00001, 8);
        hold(5'b00010, 4);
        chk("t2_row_c1", {25'd0, row}, 32'h08);
        hold(5'b00010, 4);
        hold(5'b00100, 8);
        chk("t2_fs_pulses", fs_count, 32'd1);

        // New code mid-frame waits for the next C0
        step(5'b00100, 1'b1, 4'h1, 1'b0);
        chk("t3_ready_low", {31'd0, char_ready}, 32'd0);
        hold(5'b00100, 3);
        hold(5'b01000, 8);
        hold(5'b10000, 8);
        chk("t3_row_c4_old", {25'd0, row}, 32'h08);
        hold(5'b00001, 8);
        chk("t3_row_c0_new", {25'd0, row}, 32'h00);
        chk("t3_ready_back", {31'd0, char_ready}, 32'd1);
        hold(5'b00010, 8);
        chk("t3_row_c1_new", {25'd0, row}, 32'h42);

        // Single-cycle multi-hot glitch is filtered; all-zero column blanks
        hold(5'b00010, 2);
        step(5'b00110, 1'b0, 4'h0, 1'b0);
        hold(5'b00100, 8);
        chk("t4_blank_after_glitch", {31'd0, blank}, 32'd0);
        chk("t4_row_c2", {25'd0, row}, 32'h7F);
        hold(5'b00000, 4);
        chk("t4_zero_row", {25'd0, row}, 32'h00);
        chk("t4_zero_blank", {31'd0, blank}, 32'd1);

        // Reset with a pending code discards it
        hold(5'b00001, 8);
        hold(5'b01000, 4);
        step(5'b01000, 1'b1, 4'h5, 1'b0);
        chk("t5_pending", {31'd0, char_ready}, 32'd0);
        step(5'b01000, 1'b0, 4'h0, 1'b1);
        hold(5'b01000, 4);
        hold(5'b10000, 6);
        hold(5'b00001, 6);
        chk("t5_blank_glyph_row", {25'd0, row}, 32'h00);
        chk("t5_blank_glyph_col_valid", {31'd0, blank}, 32'd0);
        chk("t5_ready", {31'd0, char_ready}, 32'd1);

`ifdef MATRIX_PWM_EN
        step(5'b00001, 1'b1, 4'hE, 1'b0);
        hold(5'b00010, 6);
        hold(5'b00001, 6);
        duty = 3'd1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            hold(5'b00001, 1);
            if (row[3] === 1'b1) n++;
        end
        chk("t6_duty1_lit", n, 32'd2);
        duty = 3'd7;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            hold(5'b00001, 1);
            if (row[3] === 1'b1) n++;
        end
        chk("t6_duty7_lit", n, 32'd8);
`endif

        // Random scan traffic with glitches, invalid columns, handshakes and rare resets
        repeat (150) begin
            n = $urandom_range(0, 9);
            if (n < 7) c = 5'd1 << $urandom_range(0, 4);
            else if (n == 7) c = 5'd0;
            else c = 5'($urandom_range(0, 31));
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
`ifdef MATRIX_PWM_EN
                if ($urandom_range(0, 15) == 0) duty = 3'($urandom_range(0, 7));
`endif
                step(c, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 199) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
